stable_dedup: RTL and testbench
===============================

STABLE_DEDUP -- requirements
Module: stable_dedup

Interface
REQ-001 SHALL have parameter K, default 3: number of top-k class IDs per frame (K >= 1).
REQ-002 SHALL have parameter W, default 5: width of each class ID.
REQ-003 SHALL have parameter MODE, default 0: 0 = ordered compare, 1 = set compare.
REQ-004 SHALL have parameter STABLE_N, default 2: consecutive matching frames required to commit (>= 1).
REQ-005 SHALL have parameter BLANK_ID, default 26: class ID meaning "no gesture".
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_next, input, 1 bit: frame strobe; i_tops valid on this cycle.
REQ-009 SHALL have port i_tops[0:K-1], input, W bits each: current frame's top-k IDs, index 0 = best.
REQ-010 SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port o_next, output, 1 bit: one-cycle commit pulse.
REQ-012 SHALL have port o_symbol, output, W bits: last committed ID, held between pulses.

Function
REQ-013 SHALL implement FSM IDLE -> CMP -> DECIDE -> IDLE.
REQ-014 In IDLE, i_next=1 SHALL latch i_tops into cur[] and clear idx and mismatch.
REQ-015 SHALL ignore i_next while o_busy=1, with no effect on state.
REQ-016 In CMP, SHALL check one element cur[idx] per cycle, then increment idx.
REQ-017 SHALL leave CMP for DECIDE after idx=K-1 (K cycles in CMP).
REQ-018 MODE=0: element mismatches if cur[idx] != prev[idx].
REQ-019 MODE=1: element mismatches if cur[idx] equals no prev[j], j in 0..K-1.
REQ-020 SHALL treat a frame with prev_valid=0 as mismatched.
REQ-021 In DECIDE, on mismatch: cnt <= 1; otherwise cnt <= min(cnt+1, STABLE_N).
REQ-022 cnt SHALL be $clog2(STABLE_N+1) bits and saturate (no wrap).
REQ-023 In DECIDE, SHALL copy prev[] <= cur[] and set prev_valid <= 1.
REQ-024 Commit condition: new cnt == STABLE_N AND cur[0] != BLANK_ID AND cur[0] != committed.
REQ-025 On commit: o_next=1 for exactly one cycle, o_symbol <= cur[0], committed <= cur[0].
REQ-026 If new cnt == STABLE_N and cur[0] == BLANK_ID: committed <= BLANK_ID, no pulse (re-arms repeats).
REQ-027 o_next and o_symbol SHALL be registered.
REQ-028 Latency: o_next high in the cycle following the (K+2)th rising edge after the edge sampling i_next.
REQ-029 Minimum frame spacing SHALL be K+2 cycles; o_busy covers all non-accepting cycles.

Reset
REQ-030 i_rst_n=0 SHALL asynchronously force: state=IDLE, idx=0, cnt=0, prev_valid=0, o_next=0, o_busy=0, o_symbol=BLANK_ID, committed=BLANK_ID.
REQ-031 Reset mid-CMP/DECIDE SHALL abort the frame with no o_next pulse.

Configuration
REQ-032 Macro STABLE_DEDUP_DROP_CNT_EN defined: SHALL add output o_drop_cnt[7:0], reset 0, +1 per i_next seen while o_busy=1, saturating at 255.
REQ-033 Macro undefined: o_drop_cnt and its logic SHALL be absent; all other behaviour identical.

Verification (K=3, STABLE_N=2, BLANK_ID=26)
REQ-034 Reset held low: o_next=0, o_busy=0, o_symbol=26.
REQ-035 Frames {0,3,6},{0,3,6} -> single o_next with o_symbol=0, 5 edges after 2nd strobe; 3rd {0,3,6} -> no pulse.
REQ-036 {1,2,3} then {1,3,2}: MODE=1 -> pulse, symbol 1; MODE=0 -> no pulse.
REQ-037 {4,5,6}x2 -> pulse 4; {26,0,4}x2 -> no pulse, o_symbol stays 4; {4,5,6}x2 -> pulse 4 again.
REQ-038 i_next re-asserted 1 cycle after accepted strobe -> ignored, no extra frame; o_drop_cnt=1 with macro.
REQ-039 Reset asserted during CMP of 2nd matching frame -> no pulse; next two {7,8,9} frames -> pulse 7.

Source files
------------

// File: rtl/stable_dedup.sv
// Top-k gesture de-duplicator: commits a class ID after STABLE_N consecutive matching frames.
// Optional STABLE_DEDUP_DROP_CNT_EN adds o_drop_cnt, counting strobes ignored while busy.
module stable_dedup #(
    parameter int K        = 3,
    parameter int W        = 5,
    parameter int MODE     = 0,
    parameter int STABLE_N = 2,
    parameter int BLANK_ID = 26
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_next,
    input  logic [W-1:0] i_tops [0:K-1],
    output logic         o_busy,
    output logic         o_next,
    output logic [W-1:0] o_symbol
`ifdef STABLE_DEDUP_DROP_CNT_EN
    ,
    output logic [7:0]   o_drop_cnt
`endif
);

    localparam int CW = $clog2(STABLE_N + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DECIDE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    cur  [0:K-1];
    logic [W-1:0]    prev [0:K-1];
    logic [IW-1:0]   idx;
    logic            mismatch;
    logic            prev_valid;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_new;
    logic [W-1:0]    committed;
    logic            pend;
    logic            elem_mis;
    logic            frame_mis;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_next) state_nxt = CMP;
            CMP:     if (idx == IW'(K - 1)) state_nxt = DECIDE;
            DECIDE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
    end

    always_comb begin
        elem_mis = 1'b0;
        if (MODE == 0) begin
            elem_mis = (cur[idx] != prev[idx]);
        end else begin
            elem_mis = 1'b1;
            for (int unsigned j = 0; j < K; j++)
                if (cur[idx] == prev[j]) elem_mis = 1'b0;
        end
    end

    always_comb begin
        frame_mis = mismatch | ~prev_valid;
        if (frame_mis)                    cnt_new = CW'(1);
        else if (cnt >= CW'(STABLE_N))    cnt_new = CW'(STABLE_N);
        else                              cnt_new = cnt + 1'b1;
    end

    // The commit decision is staged in pend so the pulse lands one cycle after DECIDE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < K; i++) begin
                cur[i]  <= '0;
                prev[i] <= '0;
            end
            idx        <= '0;
            mismatch   <= 1'b0;
            prev_valid <= 1'b0;
            cnt        <= '0;
            committed  <= W'(BLANK_ID);
            pend       <= 1'b0;
            o_next     <= 1'b0;
            o_symbol   <= W'(BLANK_ID);
        end else begin
            pend   <= 1'b0;
            o_next <= pend;
            if (pend) o_symbol <= committed;
            case (state)
                IDLE: begin
                    if (i_next) begin
                        cur      <= i_tops;
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end
                end
                CMP: begin
                    mismatch <= mismatch | elem_mis;
                    idx      <= idx + 1'b1;
                end
                DECIDE: begin
                    cnt        <= cnt_new;
                    prev       <= cur;
                    prev_valid <= 1'b1;
                    if (cnt_new == CW'(STABLE_N)) begin
                        if (cur[0] == W'(BLANK_ID)) begin
                            committed <= W'(BLANK_ID);
                        end else if (cur[0] != committed) begin
                            committed <= cur[0];
                            pend      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STABLE_DEDUP_DROP_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                   o_drop_cnt <= '0;
        else if (i_next && o_busy && o_drop_cnt != '1)  o_drop_cnt <= o_drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_stable_dedup.sv
// Scoreboard bench for stable_dedup: ordered (MODE=0) and set (MODE=1) instances share stimulus.
module tb_stable_dedup;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int SN = 2;
    localparam int BL = 26;
    localparam int WIN = K + 2;

    logic         clk;
    logic         rst_n;
    logic         nxt;
    logic [W-1:0] tops [0:K-1];
    logic         busy0, busy1, on0, on1;
    logic [W-1:0] sym0, sym1;
`ifdef STABLE_DEDUP_DROP_CNT_EN
    logic [7:0]   drop0, drop1;
`endif

    stable_dedup #(.K(K), .W(W), .MODE(0), .STABLE_N(SN), .BLANK_ID(BL)) u_ord (
        .i_clk(clk), .i_rst_n(rst_n), .i_next(nxt), .i_tops(tops),
        .o_busy(busy0), .o_next(on0), .o_symbol(sym0)
`ifdef STABLE_DEDUP_DROP_CNT_EN
        , .o_drop_cnt(drop0)
`endif
    );

    stable_dedup #(.K(K), .W(W), .MODE(1), .STABLE_N(SN), .BLANK_ID(BL)) u_set (
        .i_clk(clk), .i_rst_n(rst_n), .i_next(nxt), .i_tops(tops),
        .o_busy(busy1), .o_next(on1), .o_symbol(sym1)
`ifdef STABLE_DEDUP_DROP_CNT_EN
        , .o_drop_cnt(drop1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           pulse;
        logic [W-1:0] sym;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int passed = 0;
    int total  = 0;
    int drop_exp = 0;

    logic [W-1:0] mprev [2][K];
    bit           mpv   [2];
    int           mcnt  [2];
    logic [W-1:0] mcom  [2];
    logic [W-1:0] msym  [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            mpv[m]  = 1'b0;
            mcnt[m] = 0;
            mcom[m] = W'(BL);
            msym[m] = W'(BL);
            for (int i = 0; i < K; i++) mprev[m][i] = '0;
        end
    endfunction

    function automatic exp_t model_frame(input int m);
        exp_t e;
        bit   mis;
        bit   found;
        mis = !mpv[m];
        for (int i = 0; i < K; i++) begin
            if (m == 0) begin
                if (tops[i] != mprev[m][i]) mis = 1'b1;
            end else begin
                found = 1'b0;
                for (int j = 0; j < K; j++) if (tops[i] == mprev[m][j]) found = 1'b1;
                if (!found) mis = 1'b1;
            end
        end
        mcnt[m] = mis ? 1 : ((mcnt[m] + 1 > SN) ? SN : mcnt[m] + 1);
        for (int i = 0; i < K; i++) mprev[m][i] = tops[i];
        mpv[m] = 1'b1;
        e.pulse = 1'b0;
        if (mcnt[m] == SN) begin
            if (tops[0] == W'(BL)) begin
                mcom[m] = W'(BL);
            end else if (tops[0] != mcom[m]) begin
                mcom[m] = tops[0];
                msym[m] = tops[0];
                e.pulse = 1'b1;
            end
        end
        e.sym = msym[m];
        return e;
    endfunction

    task automatic do_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input bit dbl, input string nm);
        exp_t e;
        logic [WIN-1:0] p0, p1, pexp;
        @(negedge clk);
        tops[0] = a; tops[1] = b; tops[2] = c;
        nxt = 1'b1;
        q0.push_back(model_frame(0));
        q1.push_back(model_frame(1));
        @(posedge clk); #1;
        nxt = dbl;
        if (dbl) drop_exp++;
        p0 = '0; p1 = '0;
        for (int cy = 0; cy < WIN; cy++) begin
            @(posedge clk); #1;
            nxt = 1'b0;
            p0[cy] = on0;
            p1[cy] = on1;
        end
        e = q0.pop_front();
        pexp = e.pulse ? (WIN'(1) << (WIN - 1)) : '0;
        total++;
        if (p0 !== pexp) $display("FAIL %s ord pulses: got %b expected %b", nm, p0, pexp);
        else passed++;
        total++;
        if (sym0 !== e.sym) $display("FAIL %s ord symbol: got %0d expected %0d", nm, sym0, e.sym);
        else passed++;
        e = q1.pop_front();
        pexp = e.pulse ? (WIN'(1) << (WIN - 1)) : '0;
        total++;
        if (p1 !== pexp) $display("FAIL %s set pulses: got %b expected %b", nm, p1, pexp);
        else passed++;
        total++;
        if (sym1 !== e.sym) $display("FAIL %s set symbol: got %0d expected %0d", nm, sym1, e.sym);
        else passed++;
`ifdef STABLE_DEDUP_DROP_CNT_EN
        total++;
        if (drop0 !== 8'(drop_exp) || drop1 !== 8'(drop_exp))
            $display("FAIL %s drop_cnt: got %0d/%0d expected %0d", nm, drop0, drop1, drop_exp);
        else passed++;
`endif
    endtask

    task automatic check_reset_outputs(input string nm);
        total++;
        if (on0 !== 1'b0 || on1 !== 1'b0) $display("FAIL %s o_next: got %b%b expected 00", nm, on0, on1);
        else passed++;
        total++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL %s o_busy: got %b%b expected 00", nm, busy0, busy1);
        else passed++;
        total++;
        if (sym0 !== W'(BL) || sym1 !== W'(BL))
            $display("FAIL %s o_symbol: got %0d/%0d expected %0d", nm, sym0, sym1, BL);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nxt   = 1'b0;
        for (int i = 0; i < K; i++) tops[i] = '0;
        model_reset();
        drop_exp = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
`ifdef STABLE_DEDUP_DROP_CNT_EN
        total++;
        if (drop0 !== 8'd0 || drop1 !== 8'd0) $display("FAIL reset drop_cnt: got %0d/%0d expected 0", drop0, drop1);
        else passed++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_repeat();
        do_frame(0, 3, 6, 1'b0, "rep1");
        do_frame(0, 3, 6, 1'b0, "rep2");
        do_frame(0, 3, 6, 1'b0, "rep3");
    endtask

    task automatic test_order();
        do_frame(1, 2, 3, 1'b0, "ord1");
        do_frame(1, 3, 2, 1'b0, "ord2");
    endtask

    task automatic test_blank();
        do_frame(4, 5, 6, 1'b0, "blk1");
        do_frame(4, 5, 6, 1'b0, "blk2");
        do_frame(26, 0, 4, 1'b0, "blk3");
        do_frame(26, 0, 4, 1'b0, "blk4");
        do_frame(4, 5, 6, 1'b0, "blk5");
        do_frame(4, 5, 6, 1'b0, "blk6");
    endtask

    task automatic test_back_to_back();
        do_frame(10, 11, 12, 1'b1, "b2b1");
        do_frame(10, 11, 12, 1'b0, "b2b2");
    endtask

    task automatic test_reset_abort();
        logic [3:0] p;
        do_frame(7, 8, 9, 1'b0, "abt1");
        @(negedge clk);
        tops[0] = 7; tops[1] = 8; tops[2] = 9;
        nxt = 1'b1;
        @(posedge clk); #1;
        nxt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        drop_exp = 0;
        p = '0;
        for (int cy = 0; cy < 4; cy++) begin
            @(negedge clk);
            p[cy] = on0 | on1;
        end
        total++;
        if (p !== 4'b0) $display("FAIL abort pulses: got %b expected 0000", p);
        else passed++;
        check_reset_outputs("abort");
        rst_n = 1'b1;
        do_frame(7, 8, 9, 1'b0, "abt2");
        do_frame(7, 8, 9, 1'b0, "abt3");
    endtask

    task automatic test_random();
        logic [W-1:0] v [K];
        int pick;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < K; i++) begin
                pick = $urandom_range(0, 4);
                v[i] = (pick == 4) ? W'(BL) : W'(pick);
            end
            do_frame(v[0], v[1], v[2], 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) do_frame(v[0], v[1], v[2], 1'b0, "rand_rep");
        end
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_order();
        test_blank();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
